// File: rtl/eq_mix_seq.sv
// Multi-channel band equalizer and mixer. One shared multiplier runs the band
// gains in channel-major order, then the master volume for each channel.
module eq_mix_seq #(
   parameter int N_BANDS = 5,
   parameter int N_CH    = 2,
   parameter int SMPL_W  = 16,
   parameter int POT_W   = 12
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_CH*N_BANDS*SMPL_W-1:0]  band_smpl,
   input  logic                            band_vld,
   input  logic [N_BANDS*POT_W-1:0]        band_pot,
   input  logic [POT_W-1:0]                vol_pot,
   output logic [N_CH*SMPL_W-1:0]          out_smpl,
   output logic                            out_vld,
   output logic                            out_sat,
   output logic                            busy,
   output logic                            ovr_err
);
   localparam int ACC_W  = SMPL_W + $clog2(N_BANDS) + 1;
   localparam int PROD_W = ACC_W + POT_W + 1;
   localparam int N_PAIR = N_CH * N_BANDS;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int BD_W   = $clog2(N_BANDS);
   localparam int IX_W   = $clog2(N_PAIR);

   typedef enum logic [1:0] {IDLE, MAC, VOL, DONE} state_t;
   state_t state_q, state_d;

   logic [N_PAIR-1:0][SMPL_W-1:0]  smpl_snap;
   logic [N_BANDS-1:0][POT_W-1:0]  pot_snap;
   logic [POT_W-1:0]               vol_snap;
   logic [N_CH-1:0][ACC_W-1:0]     acc_q;
   logic [N_CH-1:0][SMPL_W-1:0]    out_q;
   logic [CH_W-1:0]                ch_q;
   logic [BD_W-1:0]                bd_q;
   logic [IX_W-1:0]                ix_q;
   logic                           sat_acc;

   logic                           accept, last_pair, last_band, last_ch;
   logic signed [ACC_W-1:0]        mul_a;
   logic [POT_W-1:0]               mul_b;
   logic signed [PROD_W-1:0]       prod, shf;
   logic [PROD_W-SMPL_W:0]         upper;
   logic                           ovf;
   logic [SMPL_W-1:0]              res;
   logic [ACC_W-1:0]               res_ext;

   assign last_pair = (ix_q == IX_W'(N_PAIR - 1));
   assign last_band = (bd_q == BD_W'(N_BANDS - 1));
   assign last_ch   = (ch_q == CH_W'(N_CH - 1));
   assign busy      = (state_q == MAC) || (state_q == VOL);
   assign out_smpl  = out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: if (band_vld) begin
            accept  = 1'b1;
            state_d = MAC;
         end
         MAC:  if (last_pair) state_d = VOL;
         VOL:  if (last_ch) state_d = DONE;
         DONE: begin
            state_d = IDLE;
            if (band_vld) begin
               accept  = 1'b1;
               state_d = MAC;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shared multiplier: band sample x band pot in MAC, accumulator x volume in VOL.
   always_comb begin
      mul_a = ACC_W'($signed(smpl_snap[ix_q]));
      mul_b = pot_snap[bd_q];
      if (state_q == VOL) begin
         mul_a = acc_q[ch_q];
         mul_b = vol_snap;
      end
   end

   assign prod  = PROD_W'(mul_a) * PROD_W'($signed({1'b0, mul_b}));
   assign shf   = prod >>> (POT_W - 1);
   assign upper = shf[PROD_W-1:SMPL_W-1];
   assign ovf   = !((&upper) || !(|upper));
   assign res   = ovf ? (shf[PROD_W-1] ? {1'b1, {(SMPL_W-1){1'b0}}}
                                       : {1'b0, {(SMPL_W-1){1'b1}}})
                      : shf[SMPL_W-1:0];
   assign res_ext = ACC_W'($signed(res));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smpl_snap <= '0;
         pot_snap  <= '0;
         vol_snap  <= '0;
         acc_q     <= '0;
         out_q     <= '0;
         ch_q      <= '0;
         bd_q      <= '0;
         ix_q      <= '0;
         sat_acc   <= 1'b0;
         out_vld   <= 1'b0;
         out_sat   <= 1'b0;
         ovr_err   <= 1'b0;
      end else begin
         out_vld <= 1'b0;
         out_sat <= 1'b0;
         ovr_err <= band_vld && busy;
         if (accept) begin
            smpl_snap <= band_smpl;
            pot_snap  <= band_pot;
            vol_snap  <= vol_pot;
            ch_q      <= '0;
            bd_q      <= '0;
            ix_q      <= '0;
            sat_acc   <= 1'b0;
         end else if (state_q == MAC) begin
            acc_q[ch_q] <= (bd_q == '0) ? res_ext : acc_q[ch_q] + res_ext;
            sat_acc     <= sat_acc | ovf;
            ix_q        <= last_pair ? '0 : ix_q + 1'b1;
            bd_q        <= last_band ? '0 : bd_q + 1'b1;
            if (last_pair)      ch_q <= '0;
            else if (last_band) ch_q <= ch_q + 1'b1;
         end else if (state_q == VOL) begin
            // Scaled result is parked in the accumulator until all channels finish.
            acc_q[ch_q] <= res_ext;
            sat_acc     <= sat_acc | ovf;
            ch_q        <= last_ch ? '0 : ch_q + 1'b1;
            if (last_ch) begin
               for (int c = 0; c < N_CH; c++)
                  out_q[c] <= (CH_W'(c) == ch_q) ? res : acc_q[c][SMPL_W-1:0];
               out_vld <= 1'b1;
               out_sat <= sat_acc | ovf;
            end
         end
      end
   end
endmodule

// File: tb/tb_eq_mix_seq.sv
// Directed bench for eq_mix_seq at default parameters; expected values are
// hand-computed constants.
module tb_eq_mix_seq;
   localparam int N_BANDS = 5;
   localparam int N_CH    = 2;
   localparam int SMPL_W  = 16;
   localparam int POT_W   = 12;

   logic                           clk = 1'b0;
   logic                           rst_n = 1'b0;
   logic [N_CH*N_BANDS*SMPL_W-1:0] band_smpl = '0;
   logic                           band_vld = 1'b0;
   logic [N_BANDS*POT_W-1:0]       band_pot = '0;
   logic [POT_W-1:0]               vol_pot = '0;
   logic [N_CH*SMPL_W-1:0]         out_smpl;
   logic                           out_vld, out_sat, busy, ovr_err;

   int n_vec = 0;
   int n_err = 0;

   eq_mix_seq #(.N_BANDS(N_BANDS), .N_CH(N_CH), .SMPL_W(SMPL_W), .POT_W(POT_W)) dut (
      .clk(clk), .rst_n(rst_n), .band_smpl(band_smpl), .band_vld(band_vld),
      .band_pot(band_pot), .vol_pot(vol_pot), .out_smpl(out_smpl),
      .out_vld(out_vld), .out_sat(out_sat), .busy(busy), .ovr_err(ovr_err)
   );

   always #5 clk = ~clk;

   function automatic logic signed [SMPL_W-1:0] och(input int c);
      return out_smpl[c*SMPL_W +: SMPL_W];
   endfunction

   task automatic set_bands(input int v0, input int v1);
      for (int b = 0; b < N_BANDS; b++) begin
         band_smpl[(0*N_BANDS+b)*SMPL_W +: SMPL_W] = SMPL_W'(v0);
         band_smpl[(1*N_BANDS+b)*SMPL_W +: SMPL_W] = SMPL_W'(v1);
      end
   endtask

   task automatic set_pots(input int p);
      for (int b = 0; b < N_BANDS; b++) band_pot[b*POT_W +: POT_W] = POT_W'(p);
   endtask

   // Strobes band_vld for one cycle (cycle 0); returns the cycle out_vld was seen, -1 on timeout.
   task automatic start_and_wait(output int lat);
      @(negedge clk);
      band_vld = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         band_vld = 1'b0;
         if (out_vld === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (out_smpl !== '0)  begin n_err++; $display("FAIL reset_out_smpl got %h want 0", out_smpl); end
      n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
      n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if ({out_sat, ovr_err} !== 2'b00) begin n_err++; $display("FAIL reset_sat_ovr got %b want 00", {out_sat, ovr_err}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unity;
      int lat;
      set_bands(1000, -1000); set_pots(2048); vol_pot = 12'd2048;
      start_and_wait(lat);
      n_vec++; if (lat !== 13) begin n_err++; $display("FAIL unity_latency got %0d want 13", lat); end
      n_vec++; if (och(0) !== 16'sd5000)  begin n_err++; $display("FAIL unity_ch0 got %0d want 5000", och(0)); end
      n_vec++; if (och(1) !== -16'sd5000) begin n_err++; $display("FAIL unity_ch1 got %0d want -5000", och(1)); end
      n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL unity_sat got %b want 0", out_sat); end
      @(negedge clk);
      n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL unity_vld_pulse got %b want 0", out_vld); end
      n_vec++; if (och(0) !== 16'sd5000) begin n_err++; $display("FAIL unity_hold got %0d want 5000", och(0)); end
   endtask

   task automatic test_saturation;
      int lat;
      set_bands(16000, 16000); set_pots(4095); vol_pot = 12'd2048;
      start_and_wait(lat);
      n_vec++; if (och(0) !== 16'sd32767) begin n_err++; $display("FAIL sat_pos_ch0 got %0d want 32767", och(0)); end
      n_vec++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL sat_pos_flag got %b want 1", out_sat); end
      @(negedge clk);
      n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL sat_flag_clear got %b want 0", out_sat); end
      set_bands(-16000, -16000);
      start_and_wait(lat);
      n_vec++; if (och(1) !== -16'sd32768) begin n_err++; $display("FAIL sat_neg_ch1 got %0d want -32768", och(1)); end
      n_vec++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL sat_neg_flag got %b want 1", out_sat); end
   endtask

   task automatic test_rounding;
      int lat;
      set_bands(-3, -3); set_pots(0); band_pot[POT_W-1:0] = 12'd1; vol_pot = 12'd2048;
      start_and_wait(lat);
      n_vec++; if (och(0) !== -16'sd1) begin n_err++; $display("FAIL round_neg got %0d want -1", och(0)); end
      set_bands(3, 3);
      start_and_wait(lat);
      n_vec++; if (och(1) !== 16'sd0) begin n_err++; $display("FAIL round_pos got %0d want 0", och(1)); end
   endtask

   task automatic test_back_to_back;
      int ovr_cnt, ovr_at, vld_cnt, vld1, vld2;
      logic signed [SMPL_W-1:0] a0, a1, b0, b1;
      ovr_cnt = 0; ovr_at = -1; vld_cnt = 0; vld1 = -1; vld2 = -1;
      a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      set_bands(1000, -1000); set_pots(2048); vol_pot = 12'd2048;
      @(negedge clk);
      band_vld = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         band_vld = 1'b0;
         if (ovr_err === 1'b1) begin ovr_cnt++; ovr_at = k; end
         if (out_vld === 1'b1) begin
            vld_cnt++;
            if (vld_cnt == 1) begin vld1 = k; a0 = och(0); a1 = och(1); end
            else begin vld2 = k; b0 = och(0); b1 = och(1); end
         end
         if (k == 5)  begin band_vld = 1'b1; set_bands(7, 7); end
         if (k == 13) begin band_vld = 1'b1; set_bands(200, -300); end
      end
      n_vec++; if (ovr_cnt !== 1 || ovr_at !== 6) begin n_err++; $display("FAIL ovr_pulse got %0d pulses at %0d want 1 at 6", ovr_cnt, ovr_at); end
      n_vec++; if (vld1 !== 13 || vld2 !== 26) begin n_err++; $display("FAIL b2b_vld_cycles got %0d,%0d want 13,26", vld1, vld2); end
      n_vec++; if (vld_cnt !== 2) begin n_err++; $display("FAIL b2b_vld_count got %0d want 2", vld_cnt); end
      n_vec++; if (a0 !== 16'sd5000 || a1 !== -16'sd5000) begin n_err++; $display("FAIL b2b_frame1 got %0d,%0d want 5000,-5000", a0, a1); end
      n_vec++; if (b0 !== 16'sd1000 || b1 !== -16'sd1500) begin n_err++; $display("FAIL b2b_frame2 got %0d,%0d want 1000,-1500", b0, b1); end
   endtask

   task automatic test_snapshot;
      int lat;
      set_bands(1000, -1000); set_pots(2048); vol_pot = 12'd2048;
      @(negedge clk);
      band_vld = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         band_vld = 1'b0;
         if (k == 1) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL snap_busy got %b want 1", busy); end
         end
         if (k == 2) begin set_pots(0); vol_pot = '0; set_bands(0, 0); end
         if (out_vld === 1'b1) begin lat = k; break; end
      end
      n_vec++; if (lat !== 13) begin n_err++; $display("FAIL snap_latency got %0d want 13", lat); end
      n_vec++; if (och(0) !== 16'sd5000 || och(1) !== -16'sd5000) begin n_err++; $display("FAIL snap_out got %0d,%0d want 5000,-5000", och(0), och(1)); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL snap_done_busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int seen;
      seen = 0;
      set_bands(1000, -1000); set_pots(2048); vol_pot = 12'd2048;
      @(negedge clk);
      band_vld = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         band_vld = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      n_vec++; if (out_smpl !== '0) begin n_err++; $display("FAIL midrst_out got %h want 0", out_smpl); end
      n_vec++; if ({out_vld, out_sat, busy, ovr_err} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags got %b want 0000", {out_vld, out_sat, busy, ovr_err}); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_vld === 1'b1) seen++;
      end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_vld got %0d strobes want 0", seen); end
      test_unity();
   endtask

   initial begin
      test_reset();
      test_unity();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_snapshot();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/eq_mix_seq.md
EQ_MIX_SEQ -- requirements
Module: eq_mix_seq

Interface
REQ-001 Parameter N_BANDS, default 5, number of equalizer bands per channel (2..16).
REQ-002 Parameter N_CH, default 2, number of audio channels (1..8).
REQ-003 Parameter SMPL_W, default 16, signed sample width.
REQ-004 Parameter POT_W, default 12, unsigned pot width.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 band_smpl  in  N_CH*N_BANDS*SMPL_W  signed filtered band samples; channel c, band b at slice index c*N_BANDS+b.
REQ-008 band_vld  in  1  one-cycle strobe, band_smpl frame valid.
REQ-009 band_pot  in  N_BANDS*POT_W  per-band gain pots, unsigned, shared by all channels.
REQ-010 vol_pot  in  POT_W  master volume pot, unsigned.
REQ-011 out_smpl  out  N_CH*SMPL_W  registered mixed output, channel c at slice c.
REQ-012 out_vld  out  1  one-cycle strobe, out_smpl updated.
REQ-013 out_sat  out  1  valid with out_vld; high if any clip occurred in that frame.
REQ-014 busy  out  1  high while a frame is being processed.
REQ-015 ovr_err  out  1  one-cycle pulse when a band_vld is dropped.

Function
REQ-016 FSM states SHALL be IDLE, MAC, VOL, DONE; reset state IDLE.
REQ-017 busy SHALL be high in MAC and VOL, low in IDLE and DONE.
REQ-018 band_vld with busy low SHALL snapshot band_smpl, band_pot, vol_pot and enter MAC; later input changes SHALL not affect the frame.
REQ-019 band_vld with busy high SHALL be ignored and ovr_err pulse the following cycle; the frame in progress is unaffected.
REQ-020 MAC SHALL process one (channel, band) pair per cycle using one shared multiplier, channel-major order, N_CH*N_BANDS cycles, then enter VOL.
REQ-021 Band term = floor((smpl * pot) / 2^(POT_W-1)) (arithmetic shift), saturated to SMPL_W signed; pot 2^(POT_W-1) is unity gain.
REQ-022 Per-channel accumulator width SHALL be SMPL_W+ceil(log2(N_BANDS))+1, cleared at the first band of each channel; it never overflows.
REQ-023 VOL SHALL take N_CH cycles, one channel per cycle: floor(acc * vol_pot / 2^(POT_W-1)) saturated to SMPL_W signed, using the same multiplier.
REQ-024 DONE SHALL last one cycle, with out_smpl updated and out_vld high; next state is IDLE, or MAC if band_vld is present in DONE (accepted, no ovr_err).
REQ-025 Latency from band_vld cycle to out_vld cycle SHALL be N_CH*(N_BANDS+1)+1 cycles (13 at defaults); throughput is one frame per latency period.
REQ-026 out_sat SHALL be set if any REQ-021 or REQ-023 saturation occurred in the frame, and be low whenever out_vld is low.
REQ-027 out_smpl SHALL hold its value between out_vld strobes.

Reset
REQ-028 On rst_n low: state IDLE, out_smpl 0, out_vld 0, out_sat 0, busy 0, ovr_err 0, accumulators and snapshots cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no out_vld; first band_vld after release is processed normally.

Verification
REQ-030 Defaults; all band_pot=2048, vol_pot=2048, ch0 bands all 1000, ch1 bands all -1000, band_vld at cycle 0 -> out_vld at cycle 13, out ch0=5000, ch1=-5000, out_sat=0.
REQ-031 All bands 16000, band_pot=4095, vol_pot=2048 -> band terms 31992, sum 159960, out ch0=32767, out_sat=1; same with -16000 -> -32768, out_sat=1.
REQ-032 Rounding: band value -3, pot 1 on band 0, other pots 0, vol_pot=2048 -> out=-1; band value 3 -> out=0.
REQ-033 band_vld at cycle 0 and 5 -> ovr_err at cycle 6, one out_vld at 13; band_vld in DONE cycle 13 -> accepted, out_vld at 26, no ovr_err.
REQ-034 Change band_pot/vol_pot to 0 at cycle 2 after band_vld -> output uses snapshot values (REQ-030 result).
REQ-035 rst_n low at cycle 6 of a frame -> all outputs 0 immediately, no out_vld; re-run REQ-030 after release passes.
